// File: rtl/pdm_mic_ctrl_pkg.sv
// ============================================================================
// Module      : pdm_mic_ctrl_pkg
// Description : Shared types and elaboration helpers for the PDM microphone
//               sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_mic_ctrl_pkg;

    // Controller states; the encoding is visible on the state output.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAKE   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        STOP   = 3'd4
    } state_t;

    // System clocks per m_clk half period (CLK_FREQ in MHz, rate in Hz).
    function automatic int calc_half_period(input int clk_freq_mhz,
                                            input int sample_rate_hz);
        longint num;
        longint den;
        num = longint'(clk_freq_mhz) * 64'sd1000000;
        den = longint'(sample_rate_hz) * 64'sd2;
        return int'(num / den);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_mic_ctrl_fifo.sv
// ============================================================================
// Module      : pdm_mic_ctrl_fifo
// Description : Two-entry valid/ready sample buffer. The head entry drives
//               the output directly; a push into a full buffer with no pop
//               in the same cycle is dropped and flagged on overrun.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_mic_ctrl_fifo #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    input  logic                  ovr_clr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun
);

    logic [DATA_WIDTH-1:0] tail;
    logic                  tail_v;
    logic                  pop;
    logic                  drop;

    assign pop  = valid && ready;
    assign drop = push && tail_v && !pop;

    // Head/tail storage: head is the output register, tail the second slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            valid  <= 1'b0;
            tail   <= '0;
            tail_v <= 1'b0;
        end else if (pop) begin
            if (tail_v) begin
                data <= tail;
                if (push) tail <= push_data;
                else      tail_v <= 1'b0;
            end else if (push) begin
                data <= push_data;
            end else begin
                valid <= 1'b0;
            end
        end else if (push) begin
            if (!valid) begin
                data  <= push_data;
                valid <= 1'b1;
            end else if (!tail_v) begin
                tail   <= push_data;
                tail_v <= 1'b1;
            end
        end
    end

    // Sticky drop flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/pdm_mic_ctrl.sv
// ============================================================================
// Module      : pdm_mic_ctrl
// Description : PDM microphone sequencing controller. Generates m_clk, waits
//               out mic wake-up, strobes the sinc3 integrators/combs, drops
//               the filter start-up transient and buffers settled samples.
//               Optional feature macro: PDM_MIC_CTRL_WAKE_EN builds the WAKE
//               state and wake counter; without it capture starts at once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_mic_ctrl
    import pdm_mic_ctrl_pkg::*;
#(
    parameter int CLK_FREQ       = 44,
    parameter int SAMPLE_RATE    = 2750000,
    parameter int DEC_RATE       = 80,
    parameter int WAKE_CYCLES    = 27500,
    parameter int SETTLE_SAMPLES = 3,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] filt_data,
    input  logic                  filt_valid,
    input  logic                  m_ready,
    input  logic                  ovr_clr,
    output logic                  m_clk,
    output logic                  samp_en,
    output logic                  dec_en,
    output logic                  flt_clr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  busy,
    output logic [2:0]            state,
    output logic                  overrun
);

    localparam int HALF_PERIOD = calc_half_period(CLK_FREQ, SAMPLE_RATE);
    localparam int HC_W        = cnt_width(HALF_PERIOD);
    localparam int DC_W        = cnt_width(DEC_RATE);
    localparam int SC_W        = cnt_width(SETTLE_SAMPLES + 1);

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);
    localparam logic [HC_W-1:0] HC_PRE  = HC_W'(HALF_PERIOD - 2);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEC_RATE - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_SAMPLES - 1);

    // With no transient to discard, capture goes straight to RUN.
    localparam state_t CAPTURE_ST = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;

    state_t                state_q;
    state_t                state_d;
    logic [HC_W-1:0]       hc;
    logic [DC_W-1:0]       dcnt;
    logic [SC_W-1:0]       scnt;
    logic                  push_v;
    logic [DATA_WIDTH-1:0] push_d;
    logic                  hc_wrap;
    logic                  m_rise;
    logic                  m_fall;
    logic                  strobe_phase;
    logic                  samp_d;
    logic                  dec_d;

    assign hc_wrap = (state_q != IDLE) && (hc == HC_LAST);
    assign m_rise  = hc_wrap && !m_clk;
    assign m_fall  = hc_wrap && m_clk;
    assign state   = state_q;

`ifdef PDM_MIC_CTRL_WAKE_EN
    localparam int              WC_W     = cnt_width(WAKE_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(WAKE_CYCLES - 1);
    localparam state_t          ENTRY_ST = WAKE;

    logic [WC_W-1:0] wcnt;
    logic            wake_done;

    assign wake_done = m_rise && (wcnt == WC_LAST);

    // Count m_clk rising edges while the microphone wakes up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wcnt <= '0;
        else if (state_q != WAKE)   wcnt <= '0;
        else if (m_rise)            wcnt <= wcnt + 1'b1;
    end
`else
    localparam state_t ENTRY_ST = CAPTURE_ST;
`endif

    // Next-state decode; dropping enable always parks through STOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = ENTRY_ST;
`ifdef PDM_MIC_CTRL_WAKE_EN
            WAKE:    if (!enable)       state_d = STOP;
                     else if (wake_done) state_d = CAPTURE_ST;
`endif
            SETTLE:  if (!enable)                         state_d = STOP;
                     else if (filt_valid && scnt == SC_LAST) state_d = RUN;
            RUN:     if (!enable) state_d = STOP;
            STOP:    if (m_fall)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are precomputed one cycle early so they leave a flop and land
    // on the last clk of the m_clk high phase.
    assign strobe_phase = (state_d == SETTLE) || (state_d == RUN);
    assign samp_d       = strobe_phase && m_clk && (hc == HC_PRE);
    assign dec_d        = samp_d && (dcnt == DC_LAST);

    // State register plus the status outputs derived from the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            flt_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            flt_clr <= (state_q == IDLE) && enable;
        end
    end

    // m_clk divider: parked low in IDLE, free-running elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc    <= '0;
            m_clk <= 1'b0;
        end else if (state_q == IDLE) begin
            hc    <= '0;
            m_clk <= 1'b0;
        end else if (hc_wrap) begin
            hc    <= '0;
            m_clk <= ~m_clk;
        end else begin
            hc    <= hc + 1'b1;
        end
    end

    // Integrator/decimation strobes and the modulo-DEC_RATE bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_en <= 1'b0;
            dec_en  <= 1'b0;
            dcnt    <= '0;
        end else begin
            samp_en <= samp_d;
            dec_en  <= dec_d;
            if (state_q == IDLE || state_q == WAKE) dcnt <= '0;
            else if (samp_d) dcnt <= dec_d ? '0 : dcnt + 1'b1;
        end
    end

    // Filter outputs discarded while the sinc3 start-up transient settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 scnt <= '0;
        else if (state_q != SETTLE) scnt <= '0;
        else if (filt_valid)        scnt <= scnt + 1'b1;
    end

    // Capture stage ahead of the buffer; only RUN samples are forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_v <= 1'b0;
            push_d <= '0;
        end else begin
            push_v <= (state_q == RUN) && filt_valid;
            if (filt_valid) push_d <= filt_data;
        end
    end

    pdm_mic_ctrl_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_v),
        .push_data (push_d),
        .ready     (m_ready),
        .ovr_clr   (ovr_clr),
        .data      (m_data),
        .valid     (m_valid),
        .overrun   (overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_pdm_mic_ctrl.sv
// ============================================================================
// Module      : tb_pdm_mic_ctrl
// Description : Self-checking bench for pdm_mic_ctrl. A timeline model
//               derives m_clk and strobes from elapsed cycles since capture
//               start; the buffer is modelled as a bounded queue.
//               Honours PDM_MIC_CTRL_WAKE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_mic_ctrl;

    localparam int HP   = 8;
    localparam int WCYC = 4;
    localparam int DEC  = 4;
    localparam int SS   = 2;
    localparam int PER  = 2 * HP;

    localparam int S_IDLE = 0, S_WAKE = 1, S_SETTLE = 2, S_RUN = 3, S_STOP = 4;
`ifdef PDM_MIC_CTRL_WAKE_EN
    localparam int ENTRY      = S_WAKE;
    localparam int FIRST_SAMP = PER * (WCYC - 1) + PER - 1;
`else
    localparam int ENTRY      = S_SETTLE;
    localparam int FIRST_SAMP = PER - 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, enable, filt_valid, m_ready, ovr_clr;
    logic [15:0] filt_data;
    logic        m_clk, samp_en, dec_en, flt_clr, m_valid, busy, overrun;
    logic [15:0] m_data;
    logic [2:0]  state;

    pdm_mic_ctrl #(
        .CLK_FREQ(44), .SAMPLE_RATE(2750000), .DEC_RATE(DEC),
        .WAKE_CYCLES(WCYC), .SETTLE_SAMPLES(SS), .DATA_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .filt_data(filt_data),
        .filt_valid(filt_valid), .m_ready(m_ready), .ovr_clr(ovr_clr),
        .m_clk(m_clk), .samp_en(samp_en), .dec_en(dec_en), .flt_clr(flt_clr),
        .m_data(m_data), .m_valid(m_valid), .busy(busy), .state(state),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          ms, t, drops, nsamp;
    logic        e_samp, e_dec, e_fclr, e_ovr, pend;
    logic [15:0] pend_d;
    logic [15:0] q[$];

    // Observation bookkeeping
    int          cyc, n_samp, n_dec, n_fclr, first_samp;
    logic        prev_mclk;
    int          rises[$];
    logic [15:0] got[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = S_IDLE; t = 0; drops = 0; nsamp = 0;
        e_samp = 0; e_dec = 0; e_fclr = 0; e_ovr = 0;
        pend = 0; pend_d = '0; q.delete();
    endtask

    // One clock edge of the specification's rules, using current inputs.
    task automatic model_step();
        bit full, popped, set;
        full   = (q.size() == 2);
        popped = (q.size() > 0) && m_ready;
        set    = 0;
        if (popped) void'(q.pop_front());
        if (pend) begin
            if (full && !popped) set = 1;
            else q.push_back(pend_d);
        end
        if (set) e_ovr = 1;
        else if (ovr_clr) e_ovr = 0;
        pend   = (ms == S_RUN) && filt_valid;
        pend_d = filt_data;

        e_fclr = 0;
        if (ms == S_IDLE) begin
            if (enable) begin
                ms = ENTRY; e_fclr = 1; t = 0; drops = 0; nsamp = 0;
            end
        end else if (ms == S_STOP) begin
            t++;
            if (t % PER == 0) begin ms = S_IDLE; t = 0; end
        end else begin
            t++;
            if (!enable) ms = S_STOP;
            else if (ms == S_WAKE && t == HP + PER * (WCYC - 1)) ms = S_SETTLE;
            else if (ms == S_SETTLE && filt_valid) begin
                drops++;
                if (drops == SS) ms = S_RUN;
            end
        end
        e_samp = (ms == S_SETTLE || ms == S_RUN) && (t % PER == PER - 1);
        e_dec  = 0;
        if (e_samp) begin
            nsamp++;
            e_dec = (nsamp % DEC == 0);
        end
    endtask

    task automatic check_all();
        chk("m_clk", m_clk, (ms == S_IDLE) ? 0 : (t / HP) % 2);
        chk("samp_en", samp_en, e_samp);
        chk("dec_en", dec_en, e_dec);
        chk("flt_clr", flt_clr, e_fclr);
        chk("state", state, ms);
        chk("busy", busy, ms != S_IDLE);
        chk("m_valid", m_valid, q.size() != 0);
        if (q.size() != 0) chk("m_data", m_data, q[0]);
        chk("overrun", overrun, e_ovr);
    endtask

    task automatic tick();
        if (m_valid && m_ready) got.push_back(m_data);
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        if (samp_en) n_samp++;
        if (dec_en)  n_dec++;
        if (flt_clr) n_fclr++;
        if (samp_en && first_samp < 0) first_samp = cyc;
        if (m_clk && !prev_mclk && rises.size() < 2) rises.push_back(cyc);
        prev_mclk = m_clk;
        check_all();
    endtask

    task automatic run_to_run();
        int budget;
        budget = 400;
        enable = 1; m_ready = 1;
        while (ms != S_RUN && budget > 0) begin
            filt_valid = (ms == S_SETTLE) && (budget % 10 == 0);
            filt_data  = 16'($urandom);
            tick();
            budget--;
        end
        filt_valid = 0;
        chk("reach_run", state, S_RUN);
    endtask

    initial begin
        int budget, cd, idle_len;
        bit done;
        rst_n = 0; enable = 0; filt_valid = 0; m_ready = 0; ovr_clr = 0;
        filt_data = '0; cyc = 0; prev_mclk = 0; first_samp = -1;
        n_samp = 0; n_dec = 0; n_fclr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("rst_m_data", m_data, 0);
        rst_n = 1;
        tick();

        // Start-up: flt_clr, m_clk period, first strobe, settle drop 1..5.
        got.delete(); rises.delete();
        n_fclr = 0; first_samp = -1; cyc = -1;
        enable = 1; m_ready = 1;
        budget = 200;
        tick();
        while (ms != S_SETTLE && budget > 0) begin tick(); budget--; end
        chk("reach_settle", state, S_SETTLE);
        for (int k = 1; k <= 5; k++) begin
            filt_valid = 1; filt_data = 16'(k);
            tick();
            filt_valid = 0;
            repeat (11) tick();
        end
        repeat (10) tick();
        chk("fclr_cnt", n_fclr, 1);
        chk("first_samp", first_samp, FIRST_SAMP);
        chk("rise_cnt", rises.size(), 2);
        if (rises.size() == 2) chk("mclk_period", rises[1] - rises[0], PER);
        chk("deliv_cnt", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("deliv_data", got[i], i + 3);

        // 40 m_clk periods of strobes.
        n_samp = 0; n_dec = 0;
        repeat (40 * PER) tick();
        chk("samp_cnt", n_samp, 40);
        chk("dec_cnt", n_dec, 10);

        // Back-pressure: two held, third dropped, drop wins over clear.
        m_ready = 0;
        for (int k = 0; k < 3; k++) begin
            filt_valid = 1; filt_data = 16'hA001 + 16'(k);
            tick();
            filt_valid = 0;
            repeat (3) tick();
        end
        chk("ovr_set", overrun, 1);
        chk("held_valid", m_valid, 1);
        filt_valid = 1; filt_data = 16'hA004;
        tick();
        filt_valid = 0; ovr_clr = 1;
        tick();
        ovr_clr = 0;
        tick();
        chk("ovr_hold", overrun, 1);
        ovr_clr = 1;
        tick();
        ovr_clr = 0;
        chk("ovr_clr", overrun, 0);
        got.delete();
        m_ready = 1;
        repeat (4) tick();
        chk("held_cnt", got.size(), 2);
        if (got.size() == 2) begin
            chk("held_0", got[0], 16'hA001);
            chk("held_1", got[1], 16'hA002);
        end

        // Randomized traffic with enable toggling through STOP/IDLE.
        cd = 300;
        for (int i = 0; i < 2500; i++) begin
            cd--;
            if (cd == 0) begin enable = ~enable; cd = $urandom_range(150, 600); end
            filt_valid = ($urandom_range(0, 5) == 0);
            filt_data  = 16'($urandom);
            m_ready    = ($urandom_range(0, 3) != 0);
            ovr_clr    = ($urandom_range(0, 15) == 0);
            tick();
        end
        filt_valid = 0; ovr_clr = 0; m_ready = 1;

        // Enable dropped mid high phase, re-raised during STOP.
        run_to_run();
        budget = 100;
        while (!(ms == S_RUN && t % PER == HP + 2) && budget > 0) begin tick(); budget--; end
        chk("mid_high", m_clk, 1);
        enable = 0; n_samp = 0; idle_len = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (state == 3'(S_STOP)) enable = 1;
            if (state == 3'(S_IDLE)) idle_len++;
            else if (idle_len > 0) done = 1;
        end
        chk("stop_samp", n_samp, 0);
        chk("idle_len", idle_len, 1);
        chk("restart", state, ENTRY);

        // Asynchronous reset while a sample is held.
        run_to_run();
        m_ready = 0; filt_valid = 1; filt_data = 16'h5A5A;
        tick();
        filt_valid = 0;
        repeat (2) tick();
        chk("pre_rst_valid", m_valid, 1);
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        chk("rst_m_data", m_data, 0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
